// File: rtl/e_mdu_if.sv
// Operand, control and result bundle between the execute stage and the multiply/divide unit.
interface e_mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] result;

    modport master (
        output A, B, MDUOp, start,
        input  busy, HI, LO, result
    );

    modport slave (
        input  A, B, MDUOp, start,
        output busy, HI, LO, result
    );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// state | meaning
// IDLE  | no operation running; mthi/mtlo accepted, start launches an operation
// RUN   | operation in flight on latched operands; busy asserted until the counter hits 1
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [31:0]     a_q, b_q;
    logic [3:0]      op_q;
    logic [31:0]     hi_q, lo_q;

    logic            op_valid;
    logic            launch;
    logic            done;
    logic            mt_hi, mt_lo;

    logic signed [63:0] prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0]     q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0]     hi_n, lo_n;
    logic            wr_hilo;

    assign op_valid = (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && op_valid) begin
                    launch  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Moves to HI/LO only land when nothing is running and nothing is being launched.
    assign mt_hi = (state == IDLE) && !bus.start && (bus.MDUOp == OP_MTHI);
    assign mt_lo = (state == IDLE) && !bus.start && (bus.MDUOp == OP_MTLO);

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes so the INT_MIN / -1 case wraps to INT_MIN with no trap.
    assign a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
    assign b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
    assign b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
    assign b_mag_safe = (b_q == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s        = a_q[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u        = a_q / b_safe;
    assign r_u        = a_q % b_safe;

    always_comb begin
        hi_n    = hi_q;
        lo_n    = lo_q;
        wr_hilo = 1'b1;
        case (op_q)
            OP_MULT: begin
                hi_n = prod_s[63:32];
                lo_n = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_n = prod_u[63:32];
                lo_n = prod_u[31:0];
            end
            OP_DIV: begin
                hi_n    = r_s;
                lo_n    = q_s;
                wr_hilo = (b_q != 32'd0);
            end
            OP_DIVU: begin
                hi_n    = r_u;
                lo_n    = q_u;
                wr_hilo = (b_q != 32'd0);
            end
            default: wr_hilo = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (launch) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.MDUOp;
                cnt  <= ((bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU)) ?
                        CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end

            if (done) begin
                if (wr_hilo) begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                end
            end else begin
                if (mt_hi) hi_q <= bus.A;
                if (mt_lo) lo_q <= bus.A;
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.result = (bus.MDUOp == OP_MFHI) ? hi_q :
                        (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule
